// File: rtl/csr_unit_if.sv
// Bus between the writeback/decode side and the machine-mode CSR file.
// Carries the CSR write, trap/mret commit, retire strobe, read port and
// the PC redirect back to ifetch.
interface csr_unit_if;
  logic        csr_wen_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic        exception_i;
  logic [63:0] mcause_i;
  logic [63:0] pc_i;
  logic        mret_i;
  logic        retire_i;
  logic [11:0] csr_raddr_i;
  logic [63:0] csr_rdata_o;
  logic        redirect_o;
  logic [63:0] redirect_pc_o;

  // Pipeline side: drives commits and read addresses, consumes read data and redirects
  modport master (
    output csr_wen_i, csr_addr_i, csr_wdata_i, exception_i, mcause_i, pc_i,
           mret_i, retire_i, csr_raddr_i,
    input  csr_rdata_o, redirect_o, redirect_pc_o
  );

  // CSR file side
  modport slave (
    input  csr_wen_i, csr_addr_i, csr_wdata_i, exception_i, mcause_i, pc_i,
           mret_i, retire_i, csr_raddr_i,
    output csr_rdata_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file. Commits CSR writes from writeback, performs trap
// entry and mret, issues a registered one-cycle PC redirect, keeps the
// mcycle/minstret counters and serves a combinational read port.
module csr_unit #(
  parameter logic [63:0] MTVEC_RESET = 64'h0,
  parameter logic [63:0] MISA_VALUE  = 64'h8000_0000_0000_1100,
  parameter bit          BYPASS      = 1'b1
) (
  input logic       clock,
  input logic       reset,
  csr_unit_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;

  logic        r_mie;
  logic        r_mpie;
  logic [63:0] r_mtvec;
  logic [63:0] r_mscratch;
  logic [63:0] r_mepc;
  logic [63:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic        r_redirect;
  logic [63:0] r_redirectPc;

  logic        w_writeOk;
  logic [63:0] w_mstatus;
  logic [63:0] w_archRead;
  logic [63:0] w_fwdData;

  // Value a register would read back after being written with data.
  // Unimplemented addresses read 0 and misa ignores writes.
  function automatic logic [63:0] maskWrite(input logic [11:0] addr,
                                            input logic [63:0] data);
    case (addr)
      ADDR_MSTATUS:  maskWrite = (data & 64'h88) | 64'h1800;
      ADDR_MISA:     maskWrite = MISA_VALUE;
      ADDR_MTVEC,
      ADDR_MEPC:     maskWrite = data & ~64'h3;
      ADDR_MSCRATCH,
      ADDR_MCAUSE,
      ADDR_MCYCLE,
      ADDR_MINSTRET: maskWrite = data;
      default:       maskWrite = 64'h0;
    endcase
  endfunction

  // A write commits only when no trap or mret claims the cycle.
  assign w_writeOk = bus.csr_wen_i & ~bus.exception_i & ~bus.mret_i;
  assign w_mstatus = {51'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_fwdData = maskWrite(bus.csr_addr_i, bus.csr_wdata_i);

  // Architected read mux
  always_comb begin
    w_archRead = 64'h0;
    case (bus.csr_raddr_i)
      ADDR_MSTATUS:  w_archRead = w_mstatus;
      ADDR_MISA:     w_archRead = MISA_VALUE;
      ADDR_MTVEC:    w_archRead = r_mtvec;
      ADDR_MSCRATCH: w_archRead = r_mscratch;
      ADDR_MEPC:     w_archRead = r_mepc;
      ADDR_MCAUSE:   w_archRead = r_mcause;
      ADDR_MCYCLE:   w_archRead = r_mcycle;
      ADDR_MINSTRET: w_archRead = r_minstret;
      default:       w_archRead = 64'h0;
    endcase
  end

  // Forward only plain CSR writes; trap and mret side effects become visible next cycle
  assign bus.csr_rdata_o = (BYPASS && w_writeOk && (bus.csr_raddr_i == bus.csr_addr_i))
                           ? w_fwdData : w_archRead;

  assign bus.redirect_o    = r_redirect;
  assign bus.redirect_pc_o = r_redirectPc;

  // State update: trap beats mret beats CSR write; a counter write beats its increment
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mie        <= 1'b0;
      r_mpie       <= 1'b0;
      r_mtvec      <= MTVEC_RESET;
      r_mscratch   <= 64'h0;
      r_mepc       <= 64'h0;
      r_mcause     <= 64'h0;
      r_mcycle     <= 64'h0;
      r_minstret   <= 64'h0;
      r_redirect   <= 1'b0;
      r_redirectPc <= 64'h0;
    end else begin
      r_mcycle   <= r_mcycle + 64'd1;
      r_redirect <= 1'b0;
      if (bus.retire_i && !bus.exception_i)
        r_minstret <= r_minstret + 64'd1;

      if (bus.exception_i) begin
        r_mepc       <= bus.pc_i & ~64'h3;
        r_mcause     <= bus.mcause_i;
        r_mpie       <= r_mie;
        r_mie        <= 1'b0;
        r_redirect   <= 1'b1;
        r_redirectPc <= r_mtvec;
      end else if (bus.mret_i) begin
        r_mie        <= r_mpie;
        r_mpie       <= 1'b1;
        r_redirect   <= 1'b1;
        r_redirectPc <= r_mepc;
      end else if (bus.csr_wen_i) begin
        case (bus.csr_addr_i)
          ADDR_MSTATUS: begin
            r_mie  <= |(bus.csr_wdata_i & 64'h08);
            r_mpie <= |(bus.csr_wdata_i & 64'h80);
          end
          ADDR_MTVEC:    r_mtvec    <= bus.csr_wdata_i & ~64'h3;
          ADDR_MSCRATCH: r_mscratch <= bus.csr_wdata_i;
          ADDR_MEPC:     r_mepc     <= bus.csr_wdata_i & ~64'h3;
          ADDR_MCAUSE:   r_mcause   <= bus.csr_wdata_i;
          ADDR_MCYCLE:   r_mcycle   <= bus.csr_wdata_i;
          ADDR_MINSTRET: r_minstret <= bus.csr_wdata_i;
          default: ;
        endcase
      end
    end
  end

endmodule
